// File: rtl/a20_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN[LEN:0] MSB-first, REPEAT+1 times.
// Define A20_PATTERN_TX_GAP_EN to insert one idle-level GAP cycle between repetitions.
module a20_pattern_tx #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] PATTERN,
  input  logic [2:0] LEN,
  input  logic [3:0] REPEAT,
  output logic       X,
  output logic       VALID,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] pat_q, pat_d;
  logic [2:0] len_q, len_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] rep_q, rep_d;
  logic       x_q, x_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          pat_d   = PATTERN;
          len_d   = LEN;
          idx_d   = LEN;
          rep_d   = REPEAT;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (idx_q != 3'd0) begin
          idx_d = idx_q - 3'd1;
        end else if (rep_q != 4'd0) begin
          rep_d = rep_q - 4'd1;
          idx_d = len_q;
`ifdef A20_PATTERN_TX_GAP_EN
          state_d = S_GAP;
`else
          state_d = S_SHIFT;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP:   state_d = S_SHIFT;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    x_d     = (state_d == S_SHIFT) ? pat_d[idx_d] : IDLE_LEVEL;
    valid_d = (state_d == S_SHIFT);
    busy_d  = (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pat_q   <= 8'd0;
      len_q   <= 3'd0;
      idx_q   <= 3'd0;
      rep_q   <= 4'd0;
      x_q     <= IDLE_LEVEL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign X     = x_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule
